// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and multi-cycle EX freeze
// with timeout supervision and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned REG_BITS   = 5,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MC_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                ex_regwr,
    input  logic                ex_memrd,
    input  logic                ex_branch_taken,
    input  logic                mc_issue,
    input  logic                mc_done,
    output logic                stall_pc,
    output logic                stall_ifid,
    output logic                bubble_idex,
    output logic                flush_ifid,
    output logic                hold_ex,
    output logic                mc_timeout_err,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam int unsigned TW = $clog2(MC_TIMEOUT + 1);

    typedef enum logic [0:0] {StRun, StMcWait} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic load_use;
    logic stall_pc_raw, stall_ifid_raw, bubble_raw, flush_raw, hold_raw;

    // x0 is never a real dependency, so ex_rd==0 can never trigger a stall.
    always_comb begin
        load_use = ex_memrd && ex_regwr && (ex_rd != '0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    always_comb begin
        state_d        = state_q;
        tmo_d          = tmo_q;
        err_d          = err_q;
        stall_pc_raw   = 1'b0;
        stall_ifid_raw = 1'b0;
        bubble_raw     = 1'b0;
        flush_raw      = 1'b0;
        hold_raw       = 1'b0;

        unique case (state_q)
            StRun: begin
                if (mc_issue) begin
                    stall_pc_raw   = 1'b1;
                    stall_ifid_raw = 1'b1;
                    hold_raw       = 1'b1;
                    tmo_d          = '0;
                    // A done in the issue cycle is a zero-wait op.
                    if (!mc_done) begin
                        state_d = StMcWait;
                    end
                end else if (ex_branch_taken) begin
                    flush_raw  = 1'b1;
                    bubble_raw = 1'b1;
                end else if (load_use) begin
                    stall_pc_raw   = 1'b1;
                    stall_ifid_raw = 1'b1;
                    bubble_raw     = 1'b1;
                end
            end
            StMcWait: begin
                stall_pc_raw   = 1'b1;
                stall_ifid_raw = 1'b1;
                hold_raw       = 1'b1;
                if (mc_done) begin
                    state_d = StRun;
                    tmo_d   = '0;
                end else if (tmo_q == TW'(MC_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StRun;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // Outputs are held low combinationally while reset is asserted.
    always_comb begin
        stall_pc    = stall_pc_raw & rst_n;
        stall_ifid  = stall_ifid_raw & rst_n;
        bubble_idex = bubble_raw & rst_n;
        flush_ifid  = flush_raw & rst_n;
        hold_ex     = hold_raw & rst_n;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_pc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mc_timeout_err = err_q;
    assign stall_cnt      = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default-parameter instance and a small one
// (MC_TIMEOUT=8, CNT_W=4) for timeout and saturation cases.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n_a;
    logic       rst_n_b;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rd;
    logic       ex_regwr;
    logic       ex_memrd;
    logic       ex_branch_taken;
    logic       mc_issue;
    logic       mc_done;

    logic        stall_pc_a, stall_ifid_a, bubble_a, flush_a, hold_a, err_a;
    logic [15:0] cnt_a;
    logic        stall_pc_b, stall_ifid_b, bubble_b, flush_b, hold_b, err_b;
    logic [3:0]  cnt_b;

    logic [4:0] outs_a;
    logic [4:0] outs_b;
    assign outs_a = {stall_pc_a, stall_ifid_a, bubble_a, flush_a, hold_a};
    assign outs_b = {stall_pc_b, stall_ifid_b, bubble_b, flush_b, hold_b};

    int checks;
    int errors;

    hazard_ctrl dut_a (
        .clk            (clk),
        .rst_n          (rst_n_a),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .ex_rd          (ex_rd),
        .ex_regwr       (ex_regwr),
        .ex_memrd       (ex_memrd),
        .ex_branch_taken(ex_branch_taken),
        .mc_issue       (mc_issue),
        .mc_done        (mc_done),
        .stall_pc       (stall_pc_a),
        .stall_ifid     (stall_ifid_a),
        .bubble_idex    (bubble_a),
        .flush_ifid     (flush_a),
        .hold_ex        (hold_a),
        .mc_timeout_err (err_a),
        .stall_cnt      (cnt_a)
    );

    hazard_ctrl #(
        .REG_BITS  (5),
        .CNT_W     (4),
        .MC_TIMEOUT(8)
    ) dut_b (
        .clk            (clk),
        .rst_n          (rst_n_b),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .ex_rd          (ex_rd),
        .ex_regwr       (ex_regwr),
        .ex_memrd       (ex_memrd),
        .ex_branch_taken(ex_branch_taken),
        .mc_issue       (mc_issue),
        .mc_done        (mc_done),
        .stall_pc       (stall_pc_b),
        .stall_ifid     (stall_ifid_b),
        .bubble_idex    (bubble_b),
        .flush_ifid     (flush_b),
        .hold_ex        (hold_b),
        .mc_timeout_err (err_b),
        .stall_cnt      (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1          = '0;
        id_rs2          = '0;
        id_use_rs1      = 1'b0;
        id_use_rs2      = 1'b0;
        ex_rd           = '0;
        ex_regwr        = 1'b0;
        ex_memrd        = 1'b0;
        ex_branch_taken = 1'b0;
        mc_issue        = 1'b0;
        mc_done         = 1'b0;
    endtask

    task automatic set_lu();
        ex_memrd   = 1'b1;
        ex_regwr   = 1'b1;
        ex_rd      = 5'd5;
        id_rs1     = 5'd5;
        id_use_rs1 = 1'b1;
    endtask

    // outs order: {stall_pc, stall_ifid, bubble_idex, flush_ifid, hold_ex}
    initial begin
        checks  = 0;
        errors  = 0;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        idle();
        #2;
        check("reset_outs_a", 32'(outs_a), 32'(5'b00000));
        check("reset_cnt_a", 32'(cnt_a), 32'd0);
        check("reset_err_a", 32'(err_a), 32'd0);
        tick();
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        // Load-use on rs1: one stall cycle then clear.
        set_lu();
        #1 check("lu_rs1", 32'(outs_a), 32'(5'b11100));
        tick();
        ex_memrd = 1'b0;
        #1 check("lu_after", 32'(outs_a), 32'(5'b00000));
        check("lu_cnt", 32'(cnt_a), 32'd1);

        // Load-use on rs2.
        idle();
        ex_memrd   = 1'b1;
        ex_regwr   = 1'b1;
        ex_rd      = 5'd12;
        id_rs2     = 5'd12;
        id_use_rs2 = 1'b1;
        #1 check("lu_rs2", 32'(outs_a), 32'(5'b11100));
        tick();

        // No-stall cases: rs1 unused, x0, non-writing load.
        idle();
        set_lu();
        id_use_rs1 = 1'b0;
        #1 check("no_use_rs1", 32'(outs_a), 32'(5'b00000));
        tick();
        ex_rd      = '0;
        id_rs1     = '0;
        id_use_rs1 = 1'b1;
        #1 check("x0_no_stall", 32'(outs_a), 32'(5'b00000));
        tick();
        set_lu();
        ex_regwr = 1'b0;
        #1 check("no_regwr", 32'(outs_a), 32'(5'b00000));
        tick();
        check("cnt_unchanged", 32'(cnt_a), 32'd2);

        // Branch beats load-use.
        set_lu();
        ex_branch_taken = 1'b1;
        #1 check("branch_lu", 32'(outs_a), 32'(5'b00110));
        tick();
        idle();
        check("branch_cnt", 32'(cnt_a), 32'd2);

        // Multi-cycle op, done 10 cycles after issue.
        mc_issue = 1'b1;
        #1 check("mc_issue", 32'(outs_a), 32'(5'b11001));
        tick();
        mc_issue = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (i == 5) begin
                set_lu();
                ex_branch_taken = 1'b1;
            end
            if (i == 6) begin
                idle();
                mc_issue = 1'b1;
            end
            #1 check("mc_wait", 32'(outs_a), 32'(5'b11001));
            tick();
            idle();
        end
        mc_done = 1'b1;
        #1 check("mc_done_cycle", 32'(outs_a), 32'(5'b11001));
        tick();
        mc_done = 1'b0;
        #1 check("mc_back_run", 32'(outs_a), 32'(5'b00000));
        check("mc_cnt", 32'(cnt_a), 32'd13);

        // Zero-wait op, then a late done in RUN.
        mc_issue = 1'b1;
        mc_done  = 1'b1;
        #1 check("zero_wait", 32'(outs_a), 32'(5'b11001));
        tick();
        mc_issue = 1'b0;
        #1 check("late_done", 32'(outs_a), 32'(5'b00000));
        tick();
        mc_done = 1'b0;
        #1 check("late_done_next", 32'(outs_a), 32'(5'b00000));
        check("zero_wait_cnt", 32'(cnt_a), 32'd14);

        // Timeout on the small instance.
        rst_n_b = 1'b0;
        #1 rst_n_b = 1'b1;
        mc_issue = 1'b1;
        #1 check("tmo_issue", 32'(outs_b), 32'(5'b11001));
        tick();
        mc_issue = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1 check("tmo_wait_hold", 32'(hold_b), 32'd1);
            check("tmo_wait_err", 32'(err_b), 32'd0);
            tick();
        end
        #1 check("tmo_err_set", 32'(err_b), 32'd1);
        check("tmo_run", 32'(outs_b), 32'(5'b00000));
        tick();
        check("tmo_err_sticky", 32'(err_b), 32'd1);

        // Reset mid-wait drops outputs and error asynchronously.
        mc_issue = 1'b1;
        tick();
        mc_issue = 1'b0;
        #1 check("rst_pre_hold", 32'(hold_b), 32'd1);
        rst_n_b = 1'b0;
        #1 check("rst_async_outs", 32'(outs_b), 32'(5'b00000));
        check("rst_async_err", 32'(err_b), 32'd0);
        check("rst_async_cnt", 32'(cnt_b), 32'd0);
        rst_n_b = 1'b1;

        // Saturation of a 4-bit stall counter.
        set_lu();
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("sat_14", 32'(cnt_b), 32'd14);
        end
        check("sat_15", 32'(cnt_b), 32'd15);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core; complements the forwarding unit by covering hazards that forwarding cannot resolve.
- Stalls IF/ID and injects ID/EX bubbles on load-use hazards.
- Flushes on taken branches.
- Freezes the front end and EX while a multi-cycle EX operation (mul/div) runs, with timeout supervision and a stall-cycle performance counter.

Parameters:
- REG_BITS, 5, register index width.
- CNT_W, 16, stall counter width.
- MC_TIMEOUT, 64, maximum MC_WAIT cycles before the timeout error is raised.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1  in  REG_BITS  rs1 of instruction in ID.
- id_rs2  in  REG_BITS  rs2 of instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  REG_BITS  destination register of instruction in EX.
- ex_regwr  in  1  EX instruction writes rd.
- ex_memrd  in  1  EX instruction is a load.
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- mc_issue  in  1  one-cycle pulse: a multi-cycle op entered EX this cycle.
- mc_done  in  1  multi-cycle unit result valid (single-cycle pulse).
- stall_pc  out  1  hold PC.
- stall_ifid  out  1  hold IF/ID register.
- bubble_idex  out  1  load NOP into ID/EX.
- flush_ifid  out  1  load NOP into IF/ID.
- hold_ex  out  1  hold ID/EX and EX/MEM (multi-cycle in progress).
- mc_timeout_err  out  1  sticky timeout flag.
- stall_cnt  out  CNT_W  saturating count of cycles with stall_pc=1.

Behaviour:
- Reset (rst_n=0, async): state=RUN, timeout counter=0, stall_cnt=0, mc_timeout_err=0. All combinational outputs are forced to 0 while rst_n=0.
- FSM states: RUN, MC_WAIT. Outputs are Mealy (same-cycle).
- Load-use condition LU = ex_memrd & ex_regwr & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- RUN priority, highest first:
  1. mc_issue: stall_pc=stall_ifid=hold_ex=1. Next state MC_WAIT, timeout counter cleared. If mc_done is also high in this cycle, stay in RUN (zero-wait op); outputs still asserted this one cycle.
  2. ex_branch_taken: flush_ifid=1, bubble_idex=1, stall_pc=0 (PC loads target), stall_ifid=0.
  3. LU: stall_pc=1, stall_ifid=1, bubble_idex=1. Exactly one stall cycle per hazard; the next cycle EX holds the bubble, so LU deasserts naturally and the MEM/WB forwarding path supplies the data.
  4. Otherwise all outputs 0.
- MC_WAIT:
  - stall_pc=stall_ifid=hold_ex=1; bubble_idex=flush_ifid=0.
  - ex_branch_taken and LU are ignored (EX is frozen).
  - mc_done: outputs remain asserted this cycle; next state RUN.
  - Timeout counter increments each MC_WAIT cycle without mc_done. When it reaches MC_TIMEOUT-1 with no done: set mc_timeout_err (sticky until reset), next state RUN, counter cleared.
  - A late mc_done arriving in RUN is ignored.
  - mc_issue in MC_WAIT is ignored.
- stall_cnt: +1 on each clock edge where stall_pc=1; saturates at all ones with no wrap.
- ID reading x0 never causes a stall, even if ex_rd=0 with ex_memrd=1.
- Reset asserted mid MC_WAIT returns to RUN immediately; outputs drop asynchronously.

Test Plan:
- Load x5 in EX (ex_memrd=1, ex_regwr=1, ex_rd=5), ID add with id_rs1=5, id_use_rs1=1 -> that cycle stall_pc=stall_ifid=bubble_idex=1. Next cycle (ex_memrd=0) all 0. stall_cnt=1.
- Same as the first case but id_rs1=5 with id_use_rs1=0; and separately ex_rd=0, id_rs1=0 -> no stall, stall_cnt unchanged.
- Taken branch together with LU in the same cycle -> flush_ifid=1, bubble_idex=1, stall_pc=0, stall_ifid=0.
- mc_issue pulse, mc_done 10 cycles later -> hold_ex/stall_pc high for 11 cycles, then RUN. stall_cnt=11. ex_branch_taken pulsed mid-wait causes no flush.
- MC_TIMEOUT=8, mc_issue with no mc_done -> mc_timeout_err=1 after 8 stall cycles, FSM back in RUN, err stays 1. rst_n low -> err=0, outputs 0 immediately (asynchronously).
- CNT_W=4, hold stall for 20 cycles -> stall_cnt saturates at 15.
